// File: rtl/mem_debug_dumper.sv
// Debug-side reader for the data-memory debug port: freezes the pipeline, walks
// NUM_WORDS addresses and streams each word MSB-first as bytes over valid/ready.
module mem_debug_dumper #(
    parameter int          NUM_WORDS = 32,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter logic [31:0] ADDR_STEP = 32'h0000_0001,
    parameter int          READ_LAT  = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    input  logic [31:0] mem_data_in,
    input  logic        tx_ready,
    output logic        debug_on,
    output logic [31:0] debug_addr,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    output logic        busy,
    output logic        done
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_SEND = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam int WORD_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam int LAT_W  = (READ_LAT > 0) ? $clog2(READ_LAT + 1) : 1;

    logic [1:0]        state_q,    state_d;
    logic [31:0]       addr_q,     addr_d;
    logic [WORD_W-1:0] word_cnt_q, word_cnt_d;
    logic [LAT_W-1:0]  lat_cnt_q,  lat_cnt_d;
    logic [1:0]        byte_idx_q, byte_idx_d;
    logic [31:0]       word_buf_q, word_buf_d;

    // Outputs decode the registered state, so tx_valid and debug_on are glitch-free
    // and debug_on stays high across the WAIT cycles between words.
    assign busy       = (state_q != S_IDLE);
    assign debug_on   = (state_q == S_WAIT) || (state_q == S_SEND);
    assign tx_valid   = (state_q == S_SEND);
    assign done       = (state_q == S_DONE);
    assign tx_data    = tx_valid ? word_buf_q[31:24] : 8'h00;
    assign debug_addr = addr_q;

    always_comb begin
        // NOTE: every next-state signal gets a default first so no path through the case infers a latch.
        state_d    = state_q;
        addr_d     = addr_q;
        word_cnt_d = word_cnt_q;
        lat_cnt_d  = lat_cnt_q;
        byte_idx_d = byte_idx_q;
        word_buf_d = word_buf_q;

        case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    state_d    = S_WAIT;
                    addr_d     = BASE_ADDR;
                    word_cnt_d = '0;
                    lat_cnt_d  = '0;
                end
            end
            S_WAIT: begin
                if (lat_cnt_q == LAT_W'(READ_LAT)) begin
                    word_buf_d = mem_data_in;
                    byte_idx_d = 2'd0;
                    state_d    = S_SEND;
                end else begin
                    lat_cnt_d = lat_cnt_q + LAT_W'(1);
                end
            end
            S_SEND: begin
                if (tx_ready) begin
                    word_buf_d = {word_buf_q[23:0], 8'h00};
                    byte_idx_d = byte_idx_q + 2'd1;
                    if (byte_idx_q == 2'd3) begin
                        if (word_cnt_q == WORD_W'(NUM_WORDS - 1)) begin
                            state_d = S_DONE;
                        end else begin
                            // 32-bit add wraps modulo 2^32 by construction.
                            addr_d     = addr_q + ADDR_STEP;
                            word_cnt_d = word_cnt_q + WORD_W'(1);
                            lat_cnt_d  = '0;
                            state_d    = S_WAIT;
                        end
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Abort overrides any transition; a partial word is simply dropped.
        if (abort && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            addr_d  = BASE_ADDR;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            addr_q     <= BASE_ADDR;
            word_cnt_q <= '0;
            lat_cnt_q  <= '0;
            byte_idx_q <= 2'd0;
            word_buf_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register updates from pre-edge values.
            state_q    <= state_d;
            addr_q     <= addr_d;
            word_cnt_q <= word_cnt_d;
            lat_cnt_q  <= lat_cnt_d;
            byte_idx_q <= byte_idx_d;
            word_buf_q <= word_buf_d;
        end
    end

endmodule

// File: tb/tb_mem_debug_dumper.sv
// Directed bench for mem_debug_dumper: three instances cover basic/backpressure/abort,
// read latency 3, and address wrap with latency 0.
module tb_mem_debug_dumper;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [2:0] start_v = 3'b000;
    logic [2:0] abort_v = 3'b000;
    logic [2:0] ready_v = 3'b000;

    wire [2:0]  on_v, valid_v, busy_v, done_v;
    wire [7:0]  data_v [3];
    wire [31:0] addr_v [3];
    wire [31:0] mem_v  [3];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] f_word(input logic [31:0] a);
        logic [7:0] b;
        b = a[7:0];
        return {b + 8'h10, b + 8'h20, b + 8'h30, b + 8'h40};
    endfunction

    // Basic memory: fixed contents, combinational.
    assign mem_v[0] = (addr_v[0] == 32'd0) ? 32'h1122_3344 :
                      (addr_v[0] == 32'd1) ? 32'hAABB_CCDD : 32'hDEAD_BEEF;

    // Slow memory: data reflects an address change exactly 3 cycles later.
    logic [31:0] d1, d2, d3;
    always @(posedge clk) begin
        d1 <= addr_v[1];
        d2 <= d1;
        d3 <= d2;
    end
    assign mem_v[1] = f_word(d3);
    assign mem_v[2] = f_word(addr_v[2]);

    mem_debug_dumper #(.NUM_WORDS(2), .BASE_ADDR(32'h0), .ADDR_STEP(32'h1), .READ_LAT(1)) u_basic (
        .clk(clk), .rst(rst), .start(start_v[0]), .abort(abort_v[0]), .mem_data_in(mem_v[0]),
        .tx_ready(ready_v[0]), .debug_on(on_v[0]), .debug_addr(addr_v[0]), .tx_data(data_v[0]),
        .tx_valid(valid_v[0]), .busy(busy_v[0]), .done(done_v[0]));

    mem_debug_dumper #(.NUM_WORDS(2), .BASE_ADDR(32'h0), .ADDR_STEP(32'h1), .READ_LAT(3)) u_lat (
        .clk(clk), .rst(rst), .start(start_v[1]), .abort(abort_v[1]), .mem_data_in(mem_v[1]),
        .tx_ready(ready_v[1]), .debug_on(on_v[1]), .debug_addr(addr_v[1]), .tx_data(data_v[1]),
        .tx_valid(valid_v[1]), .busy(busy_v[1]), .done(done_v[1]));

    mem_debug_dumper #(.NUM_WORDS(2), .BASE_ADDR(32'hFFFF_FFFF), .ADDR_STEP(32'h1), .READ_LAT(0)) u_wrap (
        .clk(clk), .rst(rst), .start(start_v[2]), .abort(abort_v[2]), .mem_data_in(mem_v[2]),
        .tx_ready(ready_v[2]), .debug_on(on_v[2]), .debug_addr(addr_v[2]), .tx_data(data_v[2]),
        .tx_valid(valid_v[2]), .busy(busy_v[2]), .done(done_v[2]));

    // Runs one complete dump on instance k and checks bytes, addresses, WAIT count and done.
    task automatic run_dump(input int k, input bit bp, input logic [63:0] exp,
                            input int exp_wait, input logic [31:0] a0, input logic [31:0] a1);
        int nbytes, ndone, nwait, pidx;
        bit fin, stall;
        logic [7:0] pdata, eb;
        logic [5:0] pat;
        nbytes = 0; ndone = 0; nwait = 0; pidx = 0;
        fin = 0; stall = 0; pdata = 8'h00;
        pat = 6'b101001;
        @(negedge clk); start_v[k] = 1'b1;
        @(negedge clk); start_v[k] = 1'b0;
        for (int cyc = 0; cyc < 80 && !fin; cyc++) begin
            if (bp && valid_v[k] && pidx < 6) begin
                ready_v[k] = pat[pidx];
                pidx++;
            end else begin
                ready_v[k] = 1'b1;
            end
            if (stall) begin
                checks++;
                if (valid_v[k] !== 1'b1 || data_v[k] !== pdata) begin
                    errors++;
                    $display("FAIL dut%0d hold: valid=%b data=%h required valid=1 data=%h", k, valid_v[k], data_v[k], pdata);
                end
            end
            if (busy_v[k] === 1'b1 && done_v[k] === 1'b0) begin
                checks++;
                if (on_v[k] !== 1'b1) begin
                    errors++;
                    $display("FAIL dut%0d debug_on: got %b required 1 (byte %0d)", k, on_v[k], nbytes);
                end
                checks++;
                if (addr_v[k] !== ((nbytes < 4) ? a0 : a1)) begin
                    errors++;
                    $display("FAIL dut%0d addr: got %h required %h", k, addr_v[k], (nbytes < 4) ? a0 : a1);
                end
                if (valid_v[k] !== 1'b1) nwait++;
            end
            if (done_v[k] === 1'b1) begin
                ndone++;
                checks++;
                if (on_v[k] !== 1'b0 || valid_v[k] !== 1'b0) begin
                    errors++;
                    $display("FAIL dut%0d done_state: debug_on=%b tx_valid=%b required 0 0", k, on_v[k], valid_v[k]);
                end
            end
            if (valid_v[k] === 1'b1 && ready_v[k] === 1'b1) begin
                checks++;
                eb = (nbytes < 8) ? exp[63 - 8*nbytes -: 8] : 8'hxx;
                if (nbytes >= 8 || data_v[k] !== eb) begin
                    errors++;
                    $display("FAIL dut%0d byte%0d: got %h required %h", k, nbytes, data_v[k], eb);
                end
                nbytes++;
            end
            if (busy_v[k] === 1'b0 && ndone > 0) fin = 1;
            stall = (valid_v[k] === 1'b1) && (ready_v[k] === 1'b0);
            pdata = data_v[k];
            if (!fin) @(negedge clk);
        end
        ready_v[k] = 1'b0;
        checks++;
        if (!fin) begin
            errors++;
            $display("FAIL dut%0d timeout: busy=%b done_count=%0d required completion", k, busy_v[k], ndone);
        end
        checks++;
        if (nbytes != 8 || ndone != 1) begin
            errors++;
            $display("FAIL dut%0d totals: bytes=%0d dones=%0d required 8 1", k, nbytes, ndone);
        end
        checks++;
        if (nwait != exp_wait) begin
            errors++;
            $display("FAIL dut%0d wait_cycles: got %0d required %0d", k, nwait, exp_wait);
        end
        checks++;
        if (on_v[k] !== 1'b0 || valid_v[k] !== 1'b0 || busy_v[k] !== 1'b0) begin
            errors++;
            $display("FAIL dut%0d idle_after: on=%b valid=%b busy=%b required 0 0 0", k, on_v[k], valid_v[k], busy_v[k]);
        end
    endtask

    task automatic check_reset_outputs(input int k, input logic [31:0] base, input string tag);
        checks++;
        if (on_v[k] !== 1'b0 || valid_v[k] !== 1'b0 || busy_v[k] !== 1'b0 || done_v[k] !== 1'b0 ||
            data_v[k] !== 8'h00 || addr_v[k] !== base) begin
            errors++;
            $display("FAIL %s dut%0d: on=%b valid=%b busy=%b done=%b data=%h addr=%h required 0 0 0 0 00 %h",
                     tag, k, on_v[k], valid_v[k], busy_v[k], done_v[k], data_v[k], addr_v[k], base);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        check_reset_outputs(0, 32'h0, "reset");
        check_reset_outputs(1, 32'h0, "reset");
        check_reset_outputs(2, 32'hFFFF_FFFF, "reset");
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check_reset_outputs(0, 32'h0, "idle_after_reset");
    endtask

    task automatic test_basic();
        run_dump(0, 1'b0, 64'h1122_3344_AABB_CCDD, 4, 32'h0, 32'h1);
    endtask

    task automatic test_backpressure();
        run_dump(0, 1'b1, 64'h1122_3344_AABB_CCDD, 4, 32'h0, 32'h1);
    endtask

    task automatic test_latency();
        run_dump(1, 1'b0, 64'h1020_3040_1121_3141, 8, 32'h0, 32'h1);
    endtask

    task automatic test_wrap();
        run_dump(2, 1'b0, 64'h0F1F_2F3F_1020_3040, 2, 32'hFFFF_FFFF, 32'h0);
    endtask

    task automatic test_abort();
        int nb;
        bit hit;
        nb = 0; hit = 0;
        @(negedge clk); start_v[0] = 1'b1;
        @(negedge clk); start_v[0] = 1'b0; ready_v[0] = 1'b1;
        for (int cyc = 0; cyc < 20 && !hit; cyc++) begin
            if (valid_v[0] === 1'b1) nb++;
            if (nb == 2) hit = 1;
            else @(negedge clk);
        end
        checks++;
        if (!hit) begin
            errors++;
            $display("FAIL abort_setup: bytes seen %0d required 2", nb);
        end
        @(negedge clk);
        checks++;
        if (data_v[0] !== 8'h33 || valid_v[0] !== 1'b1) begin
            errors++;
            $display("FAIL abort_pre: data=%h valid=%b required 33 1", data_v[0], valid_v[0]);
        end
        abort_v[0] = 1'b1; ready_v[0] = 1'b0;
        @(negedge clk);
        abort_v[0] = 1'b0;
        check_reset_outputs(0, 32'h0, "abort_idle");
        @(negedge clk);
        check_reset_outputs(0, 32'h0, "abort_no_done");
        // Restart must begin again at BASE_ADDR with the first byte of word 0.
        run_dump(0, 1'b0, 64'h1122_3344_AABB_CCDD, 4, 32'h0, 32'h1);
    endtask

    task automatic test_restart_reset();
        bit hit;
        hit = 0;
        @(negedge clk); start_v[0] = 1'b1;
        @(negedge clk); start_v[0] = 1'b0; ready_v[0] = 1'b1;
        for (int cyc = 0; cyc < 20 && !hit; cyc++) begin
            if (valid_v[0] === 1'b1) hit = 1;
            else @(negedge clk);
        end
        checks++;
        if (!hit) begin
            errors++;
            $display("FAIL guard_setup: tx_valid never rose");
        end
        @(negedge clk);
        checks++;
        if (data_v[0] !== 8'h22) begin
            errors++;
            $display("FAIL guard_byte1: data=%h required 22", data_v[0]);
        end
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0; ready_v[0] = 1'b0;
        checks++;
        if (data_v[0] !== 8'h33 || valid_v[0] !== 1'b1 || busy_v[0] !== 1'b1 || addr_v[0] !== 32'h0) begin
            errors++;
            $display("FAIL guard_start: data=%h valid=%b busy=%b addr=%h required 33 1 1 0",
                     data_v[0], valid_v[0], busy_v[0], addr_v[0]);
        end
        @(negedge clk);
        #2 rst = 1'b1;
        #1 check_reset_outputs(0, 32'h0, "async_reset");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_reset_outputs(0, 32'h0, "post_reset");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_latency();
        test_abort();
        test_restart_reset();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
